// File: rtl/unary_gen_scheduler_if.sv
// Request, generator and response signals of the shared unary-generator scheduler.
// The slave modport is the scheduler; the master modport is its environment.
interface unary_gen_scheduler_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 4,
  parameter int LEN   = 16,
  parameter int IDW   = $clog2(N_REQ)
);
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*WIDTH-1:0] req_value;
  logic [N_REQ-1:0]       req_ready;
  logic [WIDTH-1:0]       gen_ref_no;
  logic [LEN-1:0]         gen_unary;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [IDW-1:0]         rsp_id;
  logic [LEN-1:0]         rsp_unary;
  logic                   busy;
  logic                   err;

  modport master (
    output req_valid, req_value, gen_unary, rsp_ready,
    input  req_ready, gen_ref_no, rsp_valid, rsp_id, rsp_unary, busy, err
  );

  modport slave (
    input  req_valid, req_value, gen_unary, rsp_ready,
    output req_ready, gen_ref_no, rsp_valid, rsp_id, rsp_unary, busy, err
  );
endinterface

// File: rtl/unary_gen_scheduler.sv
// Round-robin scheduler sharing one registered thermometer generator among N_REQ
// requesters; returns the captured word with its owner ID and flags bad codes.
module unary_gen_scheduler #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 4,
  parameter int LEN   = 16,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  unary_gen_scheduler_if.slave  io
);

  typedef enum logic [1:0] {S_IDLE, S_GEN, S_CAP, S_RESP} state_t;

  state_t           r_state, w_next;
  logic [IDW-1:0]   r_ptr, r_id, w_win, w_ptr_nxt;
  logic [IDW:0]     w_idx;
  logic [WIDTH-1:0] r_ref, r_exp, w_val;
  logic [LEN-1:0]   r_unary;
  logic             r_valid, r_err, w_found;
  logic [N_REQ-1:0] w_ready;

  // MSB-first thermometer code: the top v bits set.
  function automatic logic [LEN-1:0] therm(input logic [WIDTH-1:0] v);
    logic [LEN-1:0] t;
    t = '0;
    for (int i = 0; i < LEN; i++)
      t[LEN-1-i] = (WIDTH'(i) < v);
    return t;
  endfunction

  // Search ascending from r_ptr with wrap; first valid requester wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = {1'b0, r_ptr} + (IDW+1)'(k);
      if (w_idx >= (IDW+1)'(N_REQ))
        w_idx = w_idx - (IDW+1)'(N_REQ);
      if (!w_found && io.req_valid[w_idx[IDW-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_idx[IDW-1:0];
      end
    end
  end

  always_comb begin
    w_val   = '0;
    w_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_win == IDW'(i))
        w_val = io.req_value[i*WIDTH +: WIDTH];
      w_ready[i] = (r_state == S_IDLE) && w_found && (w_win == IDW'(i));
    end
    w_ptr_nxt = (w_win == IDW'(N_REQ-1)) ? '0 : w_win + IDW'(1);
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_next = S_GEN;
      S_GEN:   w_next = S_CAP;
      S_CAP:   w_next = S_RESP;
      S_RESP:  if (r_valid && io.rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_id    <= '0;
      r_ref   <= '0;
      r_exp   <= '0;
      r_unary <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_ref <= w_val;
            r_exp <= w_val;
            r_id  <= w_win;
            r_ptr <= w_ptr_nxt;
          end
        end
        // Generator output reflects r_ref sampled at the end of GEN.
        S_CAP: begin
          r_unary <= io.gen_unary;
          r_valid <= 1'b1;
          if (io.gen_unary != therm(r_exp))
            r_err <= 1'b1;
        end
        S_RESP: begin
          if (io.rsp_ready)
            r_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign io.req_ready  = w_ready;
  assign io.gen_ref_no = r_ref;
  assign io.rsp_valid  = r_valid;
  assign io.rsp_id     = r_id;
  assign io.rsp_unary  = r_unary;
  assign io.busy       = (r_state != S_IDLE);
  assign io.err        = r_err;

endmodule
